// File: rtl/qoa_stream_sequencer_if.sv
// Byte stream in, LMS words and 64-bit slice words out, between SPI RX and the QOA decoder.
// valid/ready: a transfer happens on a rising clk edge where both are high; the source holds valid and data until then.
interface qoa_stream_sequencer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        lms_we;
  logic [2:0]  lms_sel;
  logic [15:0] lms_data;
  logic        slice_valid;
  logic [63:0] slice_data;
  logic        slice_ready;
  logic        last_slice;

  modport master (
    output in_valid, in_data, slice_ready,
    input  in_ready, lms_we, lms_sel, lms_data, slice_valid, slice_data, last_slice
  );

  modport slave (
    input  in_valid, in_data, slice_ready,
    output in_ready, lms_we, lms_sel, lms_data, slice_valid, slice_data, last_slice
  );
endinterface

// File: rtl/qoa_stream_sequencer.sv
// Parses the QOA file/frame headers and LMS state from a byte stream, forwards LMS words and
// assembled slices to the decoder, and tracks sample/byte budgets with sticky error reporting.
module qoa_stream_sequencer #(
   parameter int unsigned MAX_FRAME_SAMPLES = 5120,
   parameter int unsigned BYTECNT_W         = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   restart,
   qoa_stream_sequencer_if.slave  bus,
   output logic [23:0]            samplerate,
   output logic [15:0]            frame_samples,
   output logic                   file_done,
   output logic                   err,
   output logic [2:0]             err_code,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {
      S_FILE_HDR  = 3'd0,
      S_FRAME_HDR = 3'd1,
      S_LMS       = 3'd2,
      S_SLICE_RX  = 3'd3,
      S_SLICE_OUT = 3'd4,
      S_ERROR     = 3'd5
   } state_t;

   state_t               state;
   logic [3:0]           byte_idx;
   logic [31:0]          total;
   logic [15:0]          hdr_sh;
   logic [15:0]          fsize;
   logic [15:0]          remaining;
   logic [BYTECNT_W-1:0] frame_bytes;
   logic                 in_ready_q, lms_we_q, slice_valid_q, last_slice_q;
   logic [2:0]           lms_sel_q;
   logic [15:0]          lms_data_q;
   logic [63:0]          slice_data_q;

   logic                 accept;
   logic [31:0]          total_next;
   logic [15:0]          word_next;
   logic [2:0]           fault;

   assign accept     = bus.in_valid & in_ready_q;
   // The file header shifts through 'total' so the magic sits in it when byte 3 arrives.
   assign total_next = {total[23:0], bus.in_data};
   assign word_next  = {hdr_sh[7:0], bus.in_data};

   assign bus.in_ready    = in_ready_q;
   assign bus.lms_we      = lms_we_q;
   assign bus.lms_sel     = lms_sel_q;
   assign bus.lms_data    = lms_data_q;
   assign bus.slice_valid = slice_valid_q;
   assign bus.slice_data  = slice_data_q;
   assign bus.last_slice  = last_slice_q;
   assign dbg_state       = state;

   always_comb begin
      fault = 3'd0;
      case (state)
         S_FILE_HDR:
            if (accept && byte_idx == 4'd3 && total_next != 32'h716F_6166) fault = 3'd1;
            else if (accept && byte_idx == 4'd7 && total_next == 32'd0)     fault = 3'd5;
         S_FRAME_HDR:
            if (accept && byte_idx == 4'd0 && bus.in_data != 8'd1) fault = 3'd2;
            else if (accept && byte_idx == 4'd5 &&
                     (word_next == 16'd0 || 32'(word_next) > MAX_FRAME_SAMPLES)) fault = 3'd3;
         S_SLICE_OUT:
            if (bus.slice_ready && last_slice_q && frame_bytes != BYTECNT_W'(fsize)) fault = 3'd4;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILE_HDR;  byte_idx <= 4'd0;  total <= 32'd0;  hdr_sh <= 16'd0;
         fsize <= 16'd0;  remaining <= 16'd0;  frame_bytes <= '0;
         in_ready_q <= 1'b1;  lms_we_q <= 1'b0;  lms_sel_q <= 3'd0;  lms_data_q <= 16'd0;
         slice_valid_q <= 1'b0;  slice_data_q <= 64'd0;  last_slice_q <= 1'b0;
         samplerate <= 24'd0;  frame_samples <= 16'd0;
         file_done <= 1'b0;  err <= 1'b0;  err_code <= 3'd0;
      end else if (restart) begin
         state <= S_FILE_HDR;  byte_idx <= 4'd0;  total <= 32'd0;  hdr_sh <= 16'd0;
         fsize <= 16'd0;  remaining <= 16'd0;  frame_bytes <= '0;
         in_ready_q <= 1'b1;  lms_we_q <= 1'b0;  lms_sel_q <= 3'd0;  lms_data_q <= 16'd0;
         slice_valid_q <= 1'b0;  slice_data_q <= 64'd0;  last_slice_q <= 1'b0;
         samplerate <= 24'd0;  frame_samples <= 16'd0;
         file_done <= 1'b0;  err <= 1'b0;  err_code <= 3'd0;
      end else begin
         lms_we_q  <= 1'b0;
         file_done <= 1'b0;
         if (accept) begin
            hdr_sh   <= word_next;
            byte_idx <= byte_idx + 4'd1;
            if (state == S_FRAME_HDR || state == S_LMS || state == S_SLICE_RX)
               frame_bytes <= frame_bytes + BYTECNT_W'(1);
         end
         if (fault != 3'd0) begin
            state         <= S_ERROR;
            err           <= 1'b1;
            err_code      <= fault;
            in_ready_q    <= 1'b1;
            slice_valid_q <= 1'b0;
            last_slice_q  <= 1'b0;
         end else begin
            case (state)
               S_FILE_HDR: if (accept) begin
                  total <= total_next;
                  if (byte_idx == 4'd7) begin
                     byte_idx    <= 4'd0;
                     frame_bytes <= '0;
                     state       <= S_FRAME_HDR;
                  end
               end
               S_FRAME_HDR: if (accept) begin
                  if (byte_idx == 4'd3) samplerate    <= {hdr_sh, bus.in_data};
                  if (byte_idx == 4'd5) frame_samples <= word_next;
                  if (byte_idx == 4'd7) begin
                     fsize     <= word_next;
                     remaining <= frame_samples;
                     byte_idx  <= 4'd0;
                     state     <= S_LMS;
                  end
               end
               S_LMS: if (accept) begin
                  if (byte_idx[0]) begin
                     lms_we_q   <= 1'b1;
                     lms_sel_q  <= byte_idx[3:1];
                     lms_data_q <= word_next;
                  end
                  if (byte_idx == 4'd15) begin
                     byte_idx <= 4'd0;
                     state    <= S_SLICE_RX;
                  end
               end
               S_SLICE_RX: if (accept) begin
                  slice_data_q <= {slice_data_q[55:0], bus.in_data};
                  if (byte_idx == 4'd7) begin
                     byte_idx      <= 4'd0;
                     slice_valid_q <= 1'b1;
                     last_slice_q  <= (remaining <= 16'd20);
                     in_ready_q    <= 1'b0;
                     state         <= S_SLICE_OUT;
                  end
               end
               S_SLICE_OUT: if (bus.slice_ready) begin
                  slice_valid_q <= 1'b0;
                  last_slice_q  <= 1'b0;
                  in_ready_q    <= 1'b1;
                  remaining     <= (remaining > 16'd20) ? remaining - 16'd20 : 16'd0;
                  if (last_slice_q) begin
                     frame_bytes <= '0;
                     // Any file total not above this frame's count means the file is exhausted.
                     if (total <= {16'd0, frame_samples}) begin
                        total     <= 32'd0;
                        file_done <= 1'b1;
                        state     <= S_FILE_HDR;
                     end else begin
                        total <= total - {16'd0, frame_samples};
                        state <= S_FRAME_HDR;
                     end
                  end else begin
                     state <= S_SLICE_RX;
                  end
               end
               S_ERROR: ;
               default: state <= S_FILE_HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qoa_stream_sequencer.sv
// Directed and randomized stream bench for qoa_stream_sequencer with a queue-based reference model.
module tb_qoa_stream_sequencer;

   logic        clk;
   logic        rst_n;
   logic        restart;
   logic [23:0] samplerate;
   logic [15:0] frame_samples;
   logic        file_done;
   logic        err;
   logic [2:0]  err_code;
   logic [2:0]  dbg_state;

   qoa_stream_sequencer_if bus ();

   qoa_stream_sequencer #(.MAX_FRAME_SAMPLES(5120), .BYTECNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .restart       (restart),
      .bus           (bus),
      .samplerate    (samplerate),
      .frame_samples (frame_samples),
      .file_done     (file_done),
      .err           (err),
      .err_code      (err_code),
      .dbg_state     (dbg_state)
   );

   localparam logic [2:0] ST_FILE_HDR = 3'd0;
   localparam logic [2:0] ST_ERROR    = 3'd5;

   // clock / reset infrastructure
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int ready_pct = 100;
   logic ready_hold = 1'b0;

   logic [7:0]  stim_q[$];
   logic [18:0] exp_lms_q[$];
   logic [64:0] exp_slice_q[$];
   logic [23:0] exp_sr;
   logic [15:0] exp_fs;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // reference model: builds the byte stream and the events it must produce
   task automatic add_file_hdr(input logic [31:0] total, input logic [31:0] magic);
      for (int i = 3; i >= 0; i--) stim_q.push_back(magic[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) stim_q.push_back(total[i*8 +: 8]);
   endtask

   task automatic add_frame(input int fs, input int fsize_delta, input logic [23:0] sr);
      int n;
      logic [15:0] fs16, fsz, w;
      logic [63:0] s;
      n    = (fs + 19) / 20;
      fs16 = fs[15:0];
      fsz  = 16'(24 + 8 * n + fsize_delta);
      stim_q.push_back(8'd1);
      stim_q.push_back(sr[23:16]); stim_q.push_back(sr[15:8]); stim_q.push_back(sr[7:0]);
      stim_q.push_back(fs16[15:8]); stim_q.push_back(fs16[7:0]);
      stim_q.push_back(fsz[15:8]);  stim_q.push_back(fsz[7:0]);
      for (int i = 0; i < 8; i++) begin
         w = 16'($urandom);
         stim_q.push_back(w[15:8]); stim_q.push_back(w[7:0]);
         exp_lms_q.push_back({3'(i), w});
      end
      for (int k = 0; k < n; k++) begin
         s = {$urandom, $urandom};
         for (int b = 7; b >= 0; b--) stim_q.push_back(s[b*8 +: 8]);
         exp_slice_q.push_back({(k == n - 1), s});
      end
      exp_sr = sr;
      exp_fs = fs16;
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) chk("byte_accept", bus.in_ready, 1'b1);
   endtask

   task automatic send_stream();
      while (stim_q.size() != 0) send_byte(stim_q.pop_front());
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 600 && exp_slice_q.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("slice_q_drained", exp_slice_q.size(), 0);
      chk("lms_q_drained", exp_lms_q.size(), 0);
   endtask

   task automatic check_file_end();
      chk("file_done_count", done_cnt, exp_done);
      chk("state_file_hdr", dbg_state, ST_FILE_HDR);
      chk("err_clear", err, 1'b0);
      chk("samplerate", samplerate, exp_sr);
      chk("frame_samples", frame_samples, exp_fs);
   endtask

   task automatic expect_err(input logic [2:0] code);
      chk("err_set", err, 1'b1);
      chk("err_code", err_code, code);
      chk("state_error", dbg_state, ST_ERROR);
      for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
      send_stream();
      chk("err_in_ready", bus.in_ready, 1'b1);
      chk("err_sticky", err, 1'b1);
      chk("err_no_slice", bus.slice_valid, 1'b0);
      pulse_restart();
      chk("restart_err", err, 1'b0);
      chk("restart_err_code", err_code, 3'd0);
      chk("restart_state", dbg_state, ST_FILE_HDR);
      exp_lms_q.delete();
      exp_slice_q.delete();
   endtask

   // slice_ready source
   initial begin
      bus.slice_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.slice_ready = !ready_hold && ($urandom_range(0, 99) < ready_pct);
      end
   end

   // scoreboard monitor
   logic [18:0] mon_l;
   logic [64:0] mon_s;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.lms_we) begin
            if (exp_lms_q.size() == 0) chk("lms_unexpected", bus.lms_we, 1'b0);
            else begin
               mon_l = exp_lms_q.pop_front();
               chk("lms_word", {bus.lms_sel, bus.lms_data}, mon_l);
            end
         end
         if (bus.slice_valid && bus.slice_ready) begin
            if (exp_slice_q.size() == 0) chk("slice_unexpected", bus.slice_valid, 1'b0);
            else begin
               mon_s = exp_slice_q.pop_front();
               chk("slice_word", {bus.last_slice, bus.slice_data}, mon_s);
            end
         end
         if (file_done) done_cnt++;
      end
   end

   // directed sequence
   logic [7:0]  b4;
   logic [64:0] held;
   int          fs_list[$];
   int          sum, tot, nfr;

   initial begin
      rst_n = 1'b1;  restart = 1'b0;
      bus.in_valid = 1'b0;  bus.in_data = 8'd0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_lms_we", bus.lms_we, 1'b0);
      chk("rst_slice_valid", bus.slice_valid, 1'b0);
      chk("rst_last_slice", bus.last_slice, 1'b0);
      chk("rst_samplerate", samplerate, 24'd0);
      chk("rst_frame_samples", frame_samples, 16'd0);
      chk("rst_file_done", file_done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_err_code", err_code, 3'd0);
      chk("rst_state", dbg_state, ST_FILE_HDR);
      rst_n = 1'b1;

      // single frame, one slice
      ready_pct = 60;
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 0, 24'd44100);
      send_stream();
      wait_drain();
      exp_done++;
      check_file_end();

      // slice backpressure: ready held low while bytes keep coming
      ready_pct = 100;
      ready_hold = 1'b1;
      add_file_hdr(32'd40, 32'h716F6166);
      add_frame(20, 0, 24'd48000);
      add_frame(20, 0, 24'd48000);
      fork
         send_stream();
         begin
            for (int i = 0; i < 300 && !bus.slice_valid; i++) @(negedge clk);
            chk("bp_slice_valid", bus.slice_valid, 1'b1);
            held = exp_slice_q[0];
            repeat (10) begin
               @(negedge clk);
               chk("bp_in_ready_low", bus.in_ready, 1'b0);
               chk("bp_valid_held", bus.slice_valid, 1'b1);
               chk("bp_data_held", {bus.last_slice, bus.slice_data}, held);
            end
            ready_hold = 1'b0;
         end
      join
      wait_drain();
      exp_done++;
      check_file_end();

      // multi-slice frame: 45 samples -> 3 slices, last only on the third
      ready_pct = 50;
      add_file_hdr(32'd45, 32'h716F6166);
      add_frame(45, 0, 24'd22050);
      send_stream();
      wait_drain();
      exp_done++;
      check_file_end();

      // randomized multi-frame files
      for (int f = 0; f < 3; f++) begin
         ready_pct = $urandom_range(30, 100);
         nfr = $urandom_range(1, 3);
         fs_list.delete();
         sum = 0;
         for (int i = 0; i < nfr; i++) begin
            fs_list.push_back($urandom_range(1, 70));
            sum += fs_list[i];
         end
         tot = sum - $urandom_range(0, fs_list[nfr-1] - 1);
         add_file_hdr(32'(tot), 32'h716F6166);
         for (int i = 0; i < nfr; i++) add_frame(fs_list[i], 0, 24'($urandom));
         send_stream();
         wait_drain();
         exp_done++;
         check_file_end();
      end

      // bad magic "qoag"
      add_file_hdr(32'd20, 32'h716F6167);
      stim_q = stim_q[0:3];
      send_stream();
      expect_err(3'd1);

      // channels != 1
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 0, 24'd8000);
      stim_q[8] = 8'd2;
      stim_q = stim_q[0:8];
      send_stream();
      expect_err(3'd2);

      // fsamples 0 and one above the maximum
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(0, 0, 24'd8000);
      stim_q = stim_q[0:13];
      send_stream();
      expect_err(3'd3);
      add_file_hdr(32'd6000, 32'h716F6166);
      add_frame(5121, 0, 24'd8000);
      stim_q = stim_q[0:13];
      send_stream();
      expect_err(3'd3);

      // file total of zero
      add_file_hdr(32'd0, 32'h716F6166);
      send_stream();
      expect_err(3'd5);

      // fsize mismatch on a one-slice frame
      ready_pct = 100;
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 8, 24'd44100);
      send_stream();
      wait_drain();
      chk("fsize_no_done", done_cnt, exp_done);
      expect_err(3'd4);

      // restart coincident with the 4th LMS byte
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 0, 24'd44100);
      b4 = stim_q[19];
      stim_q = stim_q[0:18];
      exp_lms_q = exp_lms_q[0:0];
      exp_slice_q.delete();
      send_stream();
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.in_data = b4;  restart = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;  restart = 1'b0;
      chk("rs_state", dbg_state, ST_FILE_HDR);
      chk("rs_lms_we", bus.lms_we, 1'b0);
      chk("rs_in_ready", bus.in_ready, 1'b1);
      repeat (3) @(negedge clk);
      chk("rs_lms_q", exp_lms_q.size(), 0);
      add_file_hdr(32'd40, 32'h716F6166);
      add_frame(40, 0, 24'd16000);
      send_stream();
      wait_drain();
      exp_done++;
      check_file_end();

      // asynchronous reset in the middle of the LMS block
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 0, 24'd32000);
      stim_q = stim_q[0:20];
      exp_lms_q = exp_lms_q[0:1];
      exp_slice_q.delete();
      send_stream();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_state", dbg_state, ST_FILE_HDR);
      chk("mr_samplerate", samplerate, 24'd0);
      chk("mr_frame_samples", frame_samples, 16'd0);
      chk("mr_in_ready", bus.in_ready, 1'b1);
      chk("mr_lms_q", exp_lms_q.size(), 0);
      rst_n = 1'b1;
      add_file_hdr(32'd20, 32'h716F6166);
      add_frame(20, 0, 24'd11025);
      send_stream();
      wait_drain();
      exp_done++;
      check_file_end();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qoa_stream_sequencer.md
Name: qoa_stream_sequencer

Overview:
Byte-level controller between the SPI receive path and the QOA decode datapath. It parses the QOA file header, then each frame header and its LMS state. It forwards the LMS history/weight words and the 64-bit slice words to the decoder core, tracks sample, slice and byte budgets, and flags malformed streams. Supported: mono only (channels == 1), big-endian QOA layout.

Parameters:
MAX_FRAME_SAMPLES, 5120, upper bound on frame sample count; a larger count is an error
BYTECNT_W, 16, width of the per-frame byte counter (compared against fsize)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
restart  input  1  one-cycle pulse: abandon current parse, return to FILE_HDR
in_valid  input  1  byte available from SPI RX domain-crossed path
in_data  input  8  received byte
in_ready  output  1  byte accepted when in_valid & in_ready
lms_we  output  1  one-cycle write strobe for LMS state
lms_sel  output  3  0-3 = history[0..3], 4-7 = weights[0..3]
lms_data  output  16  signed LMS word
slice_valid  output  1  slice word available to decoder
slice_data  output  64  slice word (bits 63:60 scalefactor, 59:0 residuals)
slice_ready  input  1  decoder accepts slice when slice_valid & slice_ready
samplerate  output  24  samplerate field of the current frame
frame_samples  output  16  sample count of the current frame
last_slice  output  1  qualifies slice_valid: final slice of the frame
file_done  output  1  one-cycle pulse when all file samples are consumed
err  output  1  sticky error flag, cleared only by restart or reset
err_code  output  3  1=bad magic, 2=channels!=1, 3=fsamples 0 or >MAX, 4=fsize mismatch, 5=file total 0

Behaviour:
- Reset: state FILE_HDR. All outputs 0 except in_ready=1. Counters, samplerate, frame_samples and err_code are cleared.
- States and byte counts:
  - FILE_HDR: 8 bytes.
  - FRAME_HDR: 8 bytes.
  - LMS: 16 bytes.
  - SLICE_RX: 8 bytes.
  - SLICE_OUT: holds the assembled slice for the decoder.
  - ERROR.
- A byte is consumed only on a cycle with in_valid & in_ready. The byte index counter advances only on consumption.
- FILE_HDR:
  - Bytes 0-3 must equal 0x71 0x6F 0x61 0x66 ("qoaf"); the magic is checked on byte 3.
  - Bytes 4-7 form total_samples[31:0], MSB first. A total of 0 is error 5.
  - After byte 7 -> FRAME_HDR.
- FRAME_HDR:
  - Byte 0 is channels; any value other than 1 is error 2.
  - Bytes 1-3 form samplerate.
  - Bytes 4-5 form fsamples; a value of 0 or > MAX_FRAME_SAMPLES is error 3. The check happens on byte 5.
  - Bytes 6-7 form fsize.
  - samplerate and frame_samples update on the cycle after the final byte of each field.
  - The frame byte counter is reset to 0 at frame start and counts every consumed byte of the frame, header included.
- LMS:
  - Bytes are consumed as 8 big-endian 16-bit pairs.
  - lms_we pulses for exactly 1 cycle on the cycle after each pair's second byte is consumed.
  - lms_sel = pair index, lms_data = {hi, lo}.
  - After the 16th byte -> SLICE_RX.
  - remaining = fsamples.
- SLICE_RX:
  - 8 bytes are shifted MSB-first into slice_data.
  - On the cycle after the 8th byte: slice_valid=1, last_slice = (remaining <= 20), -> SLICE_OUT.
- SLICE_OUT:
  - in_ready=0.
  - slice_valid and slice_data are held stable until slice_ready.
  - On handshake, remaining -= 20 (saturating at 0).
  - If last_slice: the frame byte count is compared to fsize; a mismatch is error 4.
    - total_samples -= fsamples; if the result is <= 0, file_done pulses on the next cycle and the next state is FILE_HDR.
    - Otherwise the next state is FRAME_HDR.
  - Otherwise the next state is SLICE_RX.
  - slice_valid deasserts on the cycle after the handshake.
- ERROR:
  - err=1, err_code latched.
  - in_ready=1 and bytes are discarded.
  - No lms_we or slice_valid.
  - Only restart or reset exits.
- restart takes priority over every other event, including a simultaneous byte or slice handshake.
  - Next cycle: FILE_HDR, all counters cleared, err=0.
  - slice_valid drops immediately in the next cycle, without a handshake.
- rst_n deassertion mid-frame: full reset state. No partial output survives.
- Throughput: in_ready is high in every byte-accepting state, giving 1 byte per cycle. A slice costs 8 byte cycles plus at least 1 SLICE_OUT cycle.

Test Plan:
- Single frame:
  - Stimulus: file total=20, frame ch=1, sr=44100, fsamples=20, fsize=32, 16 LMS bytes, 1 slice.
  - Response: 8 lms_we pulses with sel 0..7 and correct words; one slice_valid with last_slice=1; file_done pulse; state back to FILE_HDR.
- Slice backpressure:
  - Stimulus: hold slice_ready=0 for 10 cycles while in_valid stays high.
  - Response: in_ready=0 throughout; slice_data unchanged; no bytes lost after release.
- Multi-slice frame:
  - Stimulus: fsamples=45, fsize=48.
  - Response: 3 slices; last_slice only on the 3rd; remaining saturates at 0.
- Bad magic:
  - Stimulus: first bytes "qoag".
  - Response: err=1, err_code=1, following bytes discarded with in_ready=1; a restart pulse clears err.
- fsize mismatch:
  - Stimulus: fsize=40 with a 1-slice frame.
  - Response: err_code=4 after the slice handshake.
- restart coincident with the 4th LMS byte:
  - Response: no lms_we for pair 1; state FILE_HDR; a fresh valid file then decodes correctly.
